// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command/data byte to a PS/2 device. The host first inhibits the
// bus by pulling the clock low (request-to-send), then presents a start bit
// and lets the device clock out eight data bits (LSB first) and odd parity.
// After that it releases data for the stop bit and samples the device
// acknowledge.
//
// Parameters:
//   INHIBIT_CYCLES - clk cycles the PS/2 clock is held low for request-to-send (>= 2)
//   TIMEOUT_CYCLES - max clk cycles between device clock falls before abort
//   FILTER_LEN     - length of the PS/2 clock glitch filter, in samples
// Ports:
//   clk            - system clock
//   reset          - asynchronous active-high reset
//   wr_ps2         - single-cycle request to send din (honoured only when idle)
//   din            - byte to send
//   ps2c_in        - sampled PS/2 clock line
//   ps2d_in        - sampled PS/2 data line
//   ps2c_drive_low - 1: pull PS/2 clock low, 0: release
//   ps2d_drive_low - 1: pull PS/2 data low, 0: release
//   tx_idle        - high only while idle; gates the receive path
//   tx_done_tick   - one-cycle pulse when a frame completes
//   ack_err        - valid with tx_done_tick; 1 = device did not acknowledge
//   tx_err_tick    - one-cycle pulse when a transfer aborts on timeout
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err,
    output logic       tx_err_tick
);

    localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ICW-1:0] INH_LOAD = ICW'(INHIBIT_CYCLES - 1);
    localparam logic [TCW-1:0] TMO_LOAD = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        ACK
    } state_t;

    state_t                state_q, state_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic                  fall_edge;
    logic [FILTER_LEN:0]   filt_shift;
    logic [ICW-1:0]        inh_q, inh_d;
    logic [TCW-1:0]        tmo_q, tmo_d;
    logic [3:0]            bit_q, bit_d;
    logic [8:0]            sreg_q, sreg_d;

    // Glitch filter: the filtered clock only changes once FILTER_LEN
    // consecutive samples agree, so short pulses are ignored.
    always_comb begin
        filt_shift = {ps2c_in, filt_q};
        filt_d     = filt_shift[FILTER_LEN:1];
        if (filt_q == '1) begin
            fclk_d = 1'b1;
        end else if (filt_q == '0) begin
            fclk_d = 1'b0;
        end else begin
            fclk_d = fclk_q;
        end
        fall_edge = fclk_q & ~fclk_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            filt_q  <= '1;
            fclk_q  <= 1'b1;
            inh_q   <= '0;
            tmo_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            fclk_q  <= fclk_d;
            inh_q   <= inh_d;
            tmo_q   <= tmo_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        inh_d          = inh_q;
        tmo_d          = tmo_q;
        bit_d          = bit_q;
        sreg_d         = sreg_q;
        ps2c_drive_low = 1'b0;
        ps2d_drive_low = 1'b0;
        tx_done_tick   = 1'b0;
        ack_err        = 1'b0;
        tx_err_tick    = 1'b0;
        tx_idle        = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (wr_ps2) begin
                    sreg_d  = {~^din, din};
                    inh_d   = INH_LOAD;
                    state_d = RTS;
                end
            end
            RTS: begin
                ps2c_drive_low = 1'b1;
                if (inh_q == '0) begin
                    tmo_d   = TMO_LOAD;
                    state_d = START;
                end else begin
                    inh_d = inh_q - ICW'(1);
                end
            end
            START, DATA, STOP, ACK: begin
                if (state_q == START) begin
                    ps2d_drive_low = 1'b1;
                end else if (state_q == DATA) begin
                    ps2d_drive_low = ~sreg_q[0];
                end
                // A device clock fall always takes priority over the timeout.
                if (fall_edge) begin
                    tmo_d = TMO_LOAD;
                    case (state_q)
                        START: begin
                            bit_d   = '0;
                            state_d = DATA;
                        end
                        DATA: begin
                            sreg_d = {1'b0, sreg_q[8:1]};
                            bit_d  = bit_q + 4'd1;
                            if (bit_q == 4'd8) begin
                                state_d = STOP;
                            end
                        end
                        STOP: begin
                            state_d = ACK;
                        end
                        default: begin
                            tx_done_tick = 1'b1;
                            ack_err      = ps2d_in;
                            state_d      = IDLE;
                        end
                    endcase
                end else if (tmo_q == '0) begin
                    ps2d_drive_low = 1'b0;
                    tx_err_tick    = 1'b1;
                    state_d        = IDLE;
                end else begin
                    tmo_d = tmo_q - TCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a device model generates PS/2 clocks and
// captures the transmitted bits, while a cycle-level behavioural reference
// predicts every DUT output from the line history.
module tb_ps2_tx;

    localparam int INH  = 4;
    localparam int TMO  = 50;
    localparam int FLEN = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = '0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_drive_low, ps2d_drive_low;
    logic       tx_idle, tx_done_tick, ack_err, tx_err_tick;

    // Open-collector lines: low if either side pulls low.
    assign ps2c_in = dev_clk & ~ps2c_drive_low;
    assign ps2d_in = dev_data & ~ps2d_drive_low;

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(FLEN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_ps2(wr_ps2),
        .din(din),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .ps2c_drive_low(ps2c_drive_low),
        .ps2d_drive_low(ps2d_drive_low),
        .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err(ack_err),
        .tx_err_tick(tx_err_tick)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   ncyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   err_cyc = 0;
    int   last_low = 0;
    logic last_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Reference model: mode 0 idle, 1 request-to-send, 2 frame in progress.
    // pos = device clock falls seen in this frame; fb = levels on data line.
    int   mmode, rts_left, pos, since, runlen;
    logic lastval, mfilt;
    logic fb [0:10];
    logic fall_now, err_now, e_c, e_d, e_done, e_err, e_ack;

    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            mmode   = 0;
            lastval = 1'b1;
            runlen  = FLEN;
            mfilt   = 1'b1;
            check("rst_c_drive", ps2c_drive_low, 0);
            check("rst_d_drive", ps2d_drive_low, 0);
            check("rst_tx_idle", tx_idle, 1);
            check("rst_done", tx_done_tick, 0);
            check("rst_ack_err", ack_err, 0);
            check("rst_err", tx_err_tick, 0);
        end else begin
            fall_now = mfilt && !lastval && (runlen >= FLEN);
            err_now  = 1'b0;
            e_c = 0; e_d = 0; e_done = 0; e_err = 0; e_ack = 0;
            if (mmode == 1) begin
                e_c = 1;
            end else if (mmode == 2) begin
                err_now = !fall_now && (since >= TMO);
                if (pos <= 10) e_d = ~fb[pos];
                if (err_now) begin
                    e_d   = 0;
                    e_err = 1;
                end
                if (fall_now && pos == 11) begin
                    e_done = 1;
                    e_ack  = ps2d_in;
                end
            end
            check("c_drive", ps2c_drive_low, e_c);
            check("d_drive", ps2d_drive_low, e_d);
            check("tx_idle", tx_idle, (mmode == 0));
            check("done_tick", tx_done_tick, e_done);
            check("ack_err", ack_err, e_ack);
            check("err_tick", tx_err_tick, e_err);
            if (tx_done_tick) begin
                done_cnt++;
                last_ack = ack_err;
            end
            if (tx_err_tick) begin
                err_cnt++;
                err_cyc = ncyc;
            end
            case (mmode)
                0: if (wr_ps2) begin
                    fb[0] = 1'b0;
                    for (int i = 0; i < 8; i++) fb[i+1] = din[i];
                    fb[9]  = ($countones(din) % 2 == 0);
                    fb[10] = 1'b1;
                    rts_left = INH;
                    mmode = 1;
                end
                1: begin
                    rts_left--;
                    if (rts_left == 0) begin
                        mmode = 2;
                        pos   = 0;
                        since = 1;
                    end
                end
                default: begin
                    if (fall_now) begin
                        if (pos == 11) mmode = 0;
                        else pos++;
                        since = 1;
                    end else if (err_now) begin
                        mmode = 0;
                    end else begin
                        since++;
                    end
                end
            endcase
            if (runlen >= FLEN) mfilt = lastval;
            if (ps2c_in == lastval) begin
                if (runlen < FLEN) runlen++;
            end else begin
                lastval = ps2c_in;
                runlen  = 1;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #2;
        din    = b;
        wr_ps2 = 1'b1;
        @(posedge clk);
        #2;
        wr_ps2 = 1'b0;
    endtask

    // Device side: waits for the start bit, issues nclk clock pulses, reads
    // the line just before each fall, and acknowledges on the last pulse.
    task automatic dev_frame(input int nclk, input bit ack_low, input int glitch_at,
                             output logic [7:0] rx, output logic rx_par,
                             output logic rx_stop, output logic rx_start, output bit ok);
        int budget;
        ok = 1; rx = '0; rx_par = 0; rx_stop = 0; rx_start = 1;
        budget = 0;
        while (!(ps2c_drive_low == 1'b0 && ps2d_drive_low == 1'b1) && budget < 300) begin
            wait_cyc(1);
            budget++;
        end
        if (budget >= 300) begin
            ok = 0;
            return;
        end
        rx_start = ps2d_in;
        for (int k = 1; k <= nclk; k++) begin
            if (k == glitch_at) begin
                wait_cyc(8);
                dev_clk = 1'b0;
                wait_cyc(3);
                dev_clk = 1'b1;
                wait_cyc(8);
            end else begin
                wait_cyc($urandom_range(10, 18));
            end
            if (k >= 2 && k <= 9) rx[k-2] = ps2d_in;
            else if (k == 10) rx_par = ps2d_in;
            else if (k == 11) rx_stop = ps2d_in;
            dev_clk  = 1'b0;
            last_low = ncyc + 1;
            wait_cyc($urandom_range(12, 20));
            dev_clk = 1'b1;
            if (k == 11 && ack_low) dev_data = 1'b0;
        end
        wait_cyc(4);
        dev_data = 1'b1;
    endtask

    logic [7:0] r_byte;
    logic       r_par, r_stop, r_start;
    bit         r_ok;

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!tx_idle && n < 200) begin
            wait_cyc(1);
            n++;
        end
        check({tag, "_idle_reached"}, tx_idle, 1);
    endtask

    task automatic frame_test(input string tag, input logic [7:0] b, input bit ack_low,
                              input int glitch_at);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        dev_frame(12, ack_low, glitch_at, r_byte, r_par, r_stop, r_start, r_ok);
        wait_idle(tag);
        check({tag, "_dev_ok"}, r_ok, 1);
        check({tag, "_start"}, r_start, 0);
        check({tag, "_byte"}, r_byte, b);
        check({tag, "_parity"}, r_par, ($countones(b) % 2 == 0));
        check({tag, "_stop"}, r_stop, 1);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_ack"}, last_ack, !ack_low);
        check({tag, "_no_err"}, err_cnt - e0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, d0, e0;
        logic [7:0] b;

        #1;
        check("reset_c", ps2c_drive_low, 0);
        check("reset_idle", tx_idle, 1);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);

        // Request-to-send window and canonical 0xED frame.
        d0 = done_cnt;
        send(8'hED);
        n = 0;
        while (ps2c_drive_low && n < 100) begin
            wait_cyc(1);
            n++;
        end
        check("rts_low_cycles", n, 4);
        dev_frame(12, 1'b1, 0, r_byte, r_par, r_stop, r_start, r_ok);
        wait_idle("ed");
        check("ed_byte", r_byte, 8'hED);
        check("ed_parity", r_par, 1);
        check("ed_stop", r_stop, 1);
        check("ed_done", done_cnt - d0, 1);
        check("ed_ack_err", last_ack, 0);

        // 0x00: parity 1, device does not acknowledge.
        frame_test("zero", 8'h00, 1'b0, 0);
        check("zero_parity_lit", r_par, 1);
        check("zero_ack_err_lit", last_ack, 1);

        // Second request mid-frame is ignored.
        d0 = done_cnt;
        fork
            dev_frame(12, 1'b1, 0, r_byte, r_par, r_stop, r_start, r_ok);
            begin
                send(8'hF4);
                wait_cyc(100);
                send(8'h55);
            end
        join
        wait_idle("f4");
        check("f4_byte", r_byte, 8'hF4);
        check("f4_parity", r_par, 0);
        check("f4_done_once", done_cnt - d0, 1);

        // Short clock glitch must not advance the frame.
        frame_test("glitch", 8'hA6, 1'b1, 5);

        // Device stops clocking after three falls.
        e0 = err_cnt;
        d0 = done_cnt;
        send(8'($urandom));
        dev_frame(3, 1'b1, 0, r_byte, r_par, r_stop, r_start, r_ok);
        n = 0;
        while (err_cnt == e0 && n < 200) begin
            wait_cyc(1);
            n++;
        end
        check("tmo_err_count", err_cnt - e0, 1);
        check("tmo_latency", err_cyc - last_low, 58);
        check("tmo_c_drive", ps2c_drive_low, 0);
        check("tmo_d_drive", ps2d_drive_low, 0);
        check("tmo_idle", tx_idle, 1);
        check("tmo_no_done", done_cnt - d0, 0);

        // Reset during DATA releases the lines at once and drops the frame.
        e0 = err_cnt;
        d0 = done_cnt;
        send(8'h3C);
        dev_frame(5, 1'b1, 0, r_byte, r_par, r_stop, r_start, r_ok);
        wait_cyc(2);
        check("mid_not_idle", tx_idle, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_c", ps2c_drive_low, 0);
        check("mid_rst_d", ps2d_drive_low, 0);
        check("mid_rst_idle", tx_idle, 1);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_no_err", err_cnt - e0, 0);
        frame_test("ff", 8'hFF, 1'b1, 0);
        check("ff_parity_lit", r_par, 1);

        // Random bytes and acknowledge behaviour.
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            frame_test("rand", b, 1'($urandom_range(0, 1)), 0);
        end

        wait_cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
